// File: rtl/risc16_pkg.sv
// Shared definitions for the data-memory arbiter.
//   - Owner-state encoding: which requester held the memory in the previous cycle.
//   - Requester IDs, used for the round-robin "last served" register.
//   - Width of the DMA lock hold counter and its saturating increment.
package risc16_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CPU  = 2'b01;
    localparam logic [1:0] ST_DMA  = 2'b10;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    localparam int HOLD_W = 8;

    // Increment that sticks at lim instead of wrapping.
    function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v,
                                                 input logic [HOLD_W-1:0] lim);
        return (v < lim) ? v + 1'b1 : v;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a bounded DMA lock.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   cpu_req_i       cpu request
//   dma_req_i       dma request
//   dma_lock_i      dma asks to keep ownership on a tie
//   cpu_gnt_o       cpu owns the memory this cycle (combinational)
//   dma_gnt_o       dma owns the memory this cycle (combinational)
module rr_arbiter2
    import risc16_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cpu_req_i,
    input  logic dma_req_i,
    input  logic dma_lock_i,
    output logic cpu_gnt_o,
    output logic dma_gnt_o
);

    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

    logic [1:0]        state_q, state_d;
    logic              last_q, last_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              lock_win;

    // Grant is decided in the same cycle as the request. Grants are forced
    // low while reset is asserted so the memory sees no access.
    always_comb begin
        cpu_gnt_o = 1'b0;
        dma_gnt_o = 1'b0;
        lock_win  = (state_q == ST_DMA) && dma_lock_i && (hold_cnt_q < HOLD_LIM);
        if (rst_n) begin
            if (cpu_req_i && dma_req_i) begin
                // A tie goes to the locked dma, else to whoever was not served last.
                if (lock_win || (last_q == REQ_CPU)) begin
                    dma_gnt_o = 1'b1;
                end else begin
                    cpu_gnt_o = 1'b1;
                end
            end else begin
                cpu_gnt_o = cpu_req_i;
                dma_gnt_o = dma_req_i;
            end
        end
    end

    always_comb begin
        state_d    = ST_IDLE;
        last_d     = last_q;
        hold_cnt_d = '0;
        if (cpu_gnt_o) begin
            state_d = ST_CPU;
            last_d  = REQ_CPU;
        end else if (dma_gnt_o) begin
            state_d = ST_DMA;
            last_d  = REQ_DMA;
            // Only a continued, locked dma ownership counts toward the limit.
            if ((state_q == ST_DMA) && dma_lock_i) begin
                hold_cnt_d = sat_inc(hold_cnt_q, HOLD_LIM);
            end
        end
    end

    // Reset to last=DMA so the cpu wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            last_q     <= REQ_DMA;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port data memory between the cpu
// load/store path and a loader/debug DMA port, one access per cycle.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata            cpu access request
//   cpu_gnt, cpu_stall               cpu owns memory / cpu must wait
//   cpu_rvalid, cpu_rdata            registered cpu read return
//   dma_req/lock/we/addr/wdata       dma access request (lock keeps ownership)
//   dma_gnt                          dma owns memory
//   dma_rvalid, dma_rdata            registered dma read return
//   mem_access_addr, mem_write_data  memory address / write data
//   mem_write_en, mem_read           memory strobes
//   mem_read_data                    combinational memory read data
module dmem_arbiter
    import risc16_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_lock,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic              dma_rvalid_q, dma_rvalid_d;
    logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;

    rr_arbiter2 #(
        .MAX_HOLD (MAX_HOLD)
    ) u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req_i  (cpu_req),
        .dma_req_i  (dma_req),
        .dma_lock_i (dma_lock),
        .cpu_gnt_o  (cpu_gnt),
        .dma_gnt_o  (dma_gnt)
    );

    assign cpu_stall = cpu_req & ~cpu_gnt;

    // Grants are one-hot, so a priority mux is enough; idle drives zeros.
    always_comb begin
        mem_access_addr = '0;
        mem_write_data  = '0;
        mem_write_en    = 1'b0;
        mem_read        = 1'b0;
        if (cpu_gnt) begin
            mem_access_addr = cpu_addr;
            mem_write_data  = cpu_wdata;
            mem_write_en    = cpu_we;
            mem_read        = ~cpu_we;
        end else if (dma_gnt) begin
            mem_access_addr = dma_addr;
            mem_write_data  = dma_wdata;
            mem_write_en    = dma_we;
            mem_read        = ~dma_we;
        end
    end

    assign cpu_rvalid_d = cpu_gnt & ~cpu_we;
    assign dma_rvalid_d = dma_gnt & ~dma_we;

    // Read data is captured only on a granted read and held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            cpu_rvalid_q <= cpu_rvalid_d;
            dma_rvalid_q <= dma_rvalid_d;
            if (cpu_rvalid_d) begin
                cpu_rdata_q <= mem_read_data;
            end
            if (dma_rvalid_d) begin
                dma_rdata_q <= mem_read_data;
            end
        end
    end

    assign cpu_rvalid = cpu_rvalid_q;
    assign dma_rvalid = dma_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign dma_rdata  = dma_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by a
// randomized run, all checked against a behavioural model of the arbitration
// rules and a shadow copy of the data memory.
module tb_dmem_arbiter;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 16;
    localparam int MAX_HOLD = 8;

    logic              clk;
    logic              rst_n;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt, cpu_stall, cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              dma_req, dma_lock, dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt, dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;
    logic [ADDR_W-1:0] mem_access_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write_en, mem_read;
    logic [DATA_W-1:0] mem_read_data;

    dmem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cpu_req         (cpu_req),
        .cpu_we          (cpu_we),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_gnt         (cpu_gnt),
        .cpu_stall       (cpu_stall),
        .cpu_rvalid      (cpu_rvalid),
        .cpu_rdata       (cpu_rdata),
        .dma_req         (dma_req),
        .dma_lock        (dma_lock),
        .dma_we          (dma_we),
        .dma_addr        (dma_addr),
        .dma_wdata       (dma_wdata),
        .dma_gnt         (dma_gnt),
        .dma_rvalid      (dma_rvalid),
        .dma_rdata       (dma_rdata),
        .mem_access_addr (mem_access_addr),
        .mem_write_data  (mem_write_data),
        .mem_write_en    (mem_write_en),
        .mem_read        (mem_read),
        .mem_read_data   (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment memory, driven purely by the DUT's memory port.
    logic [DATA_W-1:0] env_mem [0:255];
    assign mem_read_data = env_mem[mem_access_addr[7:0]];
    always @(posedge clk) begin
        if (mem_write_en) env_mem[mem_access_addr[7:0]] <= mem_write_data;
    end

    // Reference model: who is expected to be served, from the arbitration rules.
    // Owner codes: 0 = nobody, 1 = cpu, 2 = dma.
    logic [DATA_W-1:0] shadow [0:255];
    int                m_prev;        // owner in the previous cycle
    int                m_last;        // last requester served
    int                m_run;         // consecutive locked dma grants
    logic              e_cpu_rv, e_dma_rv;
    logic [DATA_W-1:0] e_cpu_rd, e_dma_rd;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev   = 0;
        m_last   = 2;
        m_run    = 0;
        e_cpu_rv = 1'b0;
        e_dma_rv = 1'b0;
        e_cpu_rd = '0;
        e_dma_rd = '0;
    endtask

    function automatic int model_grant();
        if (!rst_n) return 0;
        if (cpu_req && dma_req) begin
            if (m_prev == 2 && dma_lock && m_run < MAX_HOLD) return 2;
            return (m_last == 2) ? 1 : 2;
        end
        if (cpu_req) return 1;
        if (dma_req) return 2;
        return 0;
    endfunction

    task automatic model_edge(input int g);
        e_cpu_rv = 1'b0;
        e_dma_rv = 1'b0;
        if (g == 1) begin
            if (cpu_we) shadow[cpu_addr[7:0]] = cpu_wdata;
            else begin
                e_cpu_rv = 1'b1;
                e_cpu_rd = shadow[cpu_addr[7:0]];
            end
        end else if (g == 2) begin
            if (dma_we) shadow[dma_addr[7:0]] = dma_wdata;
            else begin
                e_dma_rv = 1'b1;
                e_dma_rd = shadow[dma_addr[7:0]];
            end
        end
        if (g == 2 && m_prev == 2 && dma_lock) m_run = (m_run < MAX_HOLD) ? m_run + 1 : m_run;
        else m_run = 0;
        m_prev = g;
        if (g != 0) m_last = g;
    endtask

    // One clock cycle: check combinational and registered outputs at the
    // falling edge, then advance the model on the rising edge.
    task automatic cycle();
        int g;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        logic ewe, erd;
        @(negedge clk);
        g   = model_grant();
        ea  = '0; ed = '0; ewe = 1'b0; erd = 1'b0;
        if (g == 1) begin ea = cpu_addr; ed = cpu_wdata; ewe = cpu_we; erd = !cpu_we; end
        if (g == 2) begin ea = dma_addr; ed = dma_wdata; ewe = dma_we; erd = !dma_we; end
        chk("cpu_gnt",    32'(cpu_gnt),         32'(g == 1));
        chk("dma_gnt",    32'(dma_gnt),         32'(g == 2));
        chk("cpu_stall",  32'(cpu_stall),       32'(cpu_req && g != 1));
        chk("mem_addr",   32'(mem_access_addr), 32'(ea));
        chk("mem_wdata",  32'(mem_write_data),  32'(ed));
        chk("mem_we",     32'(mem_write_en),    32'(ewe));
        chk("mem_read",   32'(mem_read),        32'(erd));
        chk("cpu_rvalid", 32'(cpu_rvalid),      32'(e_cpu_rv));
        chk("dma_rvalid", 32'(dma_rvalid),      32'(e_dma_rv));
        chk("cpu_rdata",  32'(cpu_rdata),       32'(e_cpu_rd));
        chk("dma_rdata",  32'(dma_rdata),       32'(e_dma_rd));
        chk("hold_cnt",   32'(dut.u_arb.hold_cnt_q), 32'(m_run));
        @(posedge clk);
        model_edge(g);
        #1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_cpu_gnt",    32'(cpu_gnt),      32'd0);
        chk("rst_dma_gnt",    32'(dma_gnt),      32'd0);
        chk("rst_mem_we",     32'(mem_write_en), 32'd0);
        chk("rst_mem_read",   32'(mem_read),     32'd0);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid),   32'd0);
        chk("rst_dma_rvalid", 32'(dma_rvalid),   32'd0);
        chk("rst_cpu_rdata",  32'(cpu_rdata),    32'd0);
        chk("rst_dma_rdata",  32'(dma_rdata),    32'd0);
        chk("rst_hold_cnt",   32'(dut.u_arb.hold_cnt_q), 32'd0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_lock = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = 16'($urandom);
            shadow[i]  = env_mem[i];
        end
        env_mem[4] = 16'h1234;
        shadow[4]  = 16'h1234;
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #2;
        apply_reset();

        // Lone cpu read of 0x0004, data returned the next cycle.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0004;
        cycle();
        cpu_req = 1'b0;
        cycle();
        chk("cpu_read_0004", 32'(cpu_rdata), 32'h1234);

        // Both request with no lock: cpu first, then alternating.
        apply_reset();
        cpu_req = 1'b1; dma_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cpu_addr = 16'($urandom_range(0, 15));
            dma_addr = 16'($urandom_range(0, 15));
            cycle();
        end

        // Locked dma with cpu waiting: bounded burst, then a forced cpu slot.
        apply_reset();
        cpu_req = 1'b1; dma_req = 1'b1; dma_lock = 1'b1;
        for (int i = 0; i < 14; i++) begin
            dma_addr = 16'($urandom_range(0, 15));
            cycle();
        end
        idle_inputs();
        cycle();

        // dma writes 0x00AA to 0x0010, then the cpu reads it back.
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0010; dma_wdata = 16'h00AA;
        cycle();
        idle_inputs();
        cpu_req = 1'b1; cpu_addr = 16'h0010;
        cycle();
        cpu_req = 1'b0;
        cycle();
        chk("cpu_read_0010", 32'(cpu_rdata), 32'h00AA);

        // Reset asserted in the middle of a granted cpu read.
        cpu_req = 1'b1; cpu_addr = 16'h0004;
        cycle();
        cpu_addr = 16'h0005;
        @(negedge clk);
        chk("pre_rst_cpu_gnt",    32'(cpu_gnt),    32'd1);
        chk("pre_rst_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        #1;
        apply_reset();
        dma_req = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // Five idle cycles.
        idle_inputs();
        for (int i = 0; i < 5; i++) cycle();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cpu_req   = 1'($urandom_range(0, 3) != 0);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = 16'($urandom_range(0, 15));
            cpu_wdata = 16'($urandom);
            dma_req   = 1'($urandom_range(0, 3) != 0);
            dma_lock  = 1'($urandom_range(0, 4) != 0);
            dma_we    = 1'($urandom_range(0, 1));
            dma_addr  = 16'($urandom_range(0, 15));
            dma_wdata = 16'($urandom);
            cycle();
        end
        idle_inputs();
        cycle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the processor load/store path (cpu) and a loader/debug DMA port (dma).
- Sits between the datapath and the data memory, driving the memory's address, write-data, write-enable and read-enable inputs.
- Performs one access per cycle using round-robin arbitration, with an optional bounded DMA burst lock.
- Registers read data and returns it with a one-cycle valid pulse; generates a stall for the processor when it is not granted.

Parameters:
- ADDR_W, 16, address width of both requester ports and the memory port
- DATA_W, 16, data width
- MAX_HOLD, 8, maximum consecutive locked DMA grants before the cpu is forced a slot (legal range 1..255)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  cpu access request, held until granted
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  ADDR_W  cpu address
- cpu_wdata  in  DATA_W  cpu write data
- cpu_gnt  out  1  cpu owns the memory this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rvalid  out  1  one-cycle pulse, cpu_rdata valid
- cpu_rdata  out  DATA_W  registered cpu read data
- dma_req  in  1  dma access request
- dma_lock  in  1  request to keep ownership for the next cycle
- dma_we  in  1  1=write, 0=read
- dma_addr  in  ADDR_W  dma address
- dma_wdata  in  DATA_W  dma write data
- dma_gnt  out  1  dma owns the memory this cycle
- dma_rvalid  out  1  one-cycle pulse, dma_rdata valid
- dma_rdata  out  DATA_W  registered dma read data
- mem_access_addr  out  ADDR_W  to data memory
- mem_write_data  out  DATA_W  to data memory
- mem_write_en  out  1  to data memory
- mem_read  out  1  to data memory
- mem_read_data  in  DATA_W  combinational read data from data memory

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, last=DMA (cpu wins the first tie), hold_cnt=0, both rvalid=0, both rdata=0. While rst_n=0, both gnt=0 and mem_write_en=mem_read=0.
- States and held registers: IDLE, CPU, DMA (owner granted in the previous cycle). Registers last (last served requester) and hold_cnt (8 bits).
- Grant decision is combinational from the registered state and the current requests; zero-latency grant.
  - Only one requester active: it is granted.
  - Both active, state=DMA, dma_lock=1, hold_cnt<MAX_HOLD: dma granted.
  - Both active, otherwise: the requester that is not `last` is granted (round-robin).
  - Neither active: no grant, next state IDLE.
- Lock limits:
  - dma_lock is ignored when cpu_req=0; dma simply keeps winning.
  - dma_lock with dma_req=0 has no effect.
- hold_cnt update:
  - Increments on each cycle dma is granted while state=DMA and dma_lock=1; saturates at MAX_HOLD.
  - Clears on any cpu grant, on an idle cycle, and on a dma grant with dma_lock=0.
- Memory mux: fields of the granted port drive mem_access_addr and mem_write_data. With no grant, addr and data are driven to 0.
  - mem_write_en = gnt & we.
  - mem_read = gnt & ~we.
- Writes complete at the rising edge ending the grant cycle; the requester drops req or presents its next access.
- Read return: on the edge ending a granted read, mem_read_data is captured into that port's rdata, and rvalid=1 for exactly the following cycle.
  - rdata holds its value until the next read for that port.
  - Back-to-back reads give consecutive rvalid pulses.
- Never grants both ports in one cycle. cpu_stall is purely combinational.
- Reset mid-operation: all registers clear immediately. An in-flight rvalid is lost and pending writes are not issued.
- Same-address cpu write and dma read in consecutive cycles: the read sees the written value (memory ordering, no bypass needed).

Decomposition:
- Shared package `risc16_pkg`: the owner-state encoding (IDLE=2'b00, CPU=2'b01, DMA=2'b10) and the requester ID constants.
- Natural sub-module: `rr_arbiter2`, the two-way round-robin grant logic with lock/hold counter.
- The top module holds the memory mux and the read-return registers.

Test Plan:
- cpu_req alone, read addr 0x0004 (mem holds 0x1234) -> cpu_gnt=1 same cycle, cpu_rvalid=1 next cycle with cpu_rdata=0x1234, cpu_stall=0.
- After reset, both request continuously with lock=0 -> first grant cpu, then alternating dma, cpu, dma. cpu_stall=1 exactly on dma cycles.
- dma_lock=1 with cpu_req held, MAX_HOLD=8 -> dma granted 8 consecutive cycles after the first dma slot, then cpu granted one cycle, then dma resumes.
- dma write 0x00AA to addr 0x0010, then cpu read of 0x0010 -> mem_write_en=1 only in the dma cycle; cpu_rdata=0x00AA.
- Assert rst_n=0 during a granted cpu read -> gnt, mem_read and rvalid drop immediately. After release: state IDLE, cpu wins the first tie.
- No requests for 5 cycles -> mem_write_en=mem_read=0, addr=0, hold_cnt=0, no rvalid pulses.
